// File: rtl/parity_codec_pkg.sv
// Shared definitions for the parity-protected one-hot link (encoder and decoder sides).
package parity_codec_pkg;

    // Default link geometry: 3-bit index expands to an 8-bit one-hot word.
    localparam int unsigned CODE_W_DFLT = 3;
    localparam int unsigned OUT_W_DFLT  = 2 ** CODE_W_DFLT;

    typedef enum logic [0:0] {
        StRun,
        StHalt
    } dec_state_e;

    // XOR reduction over a zero-extended word; both sides of the link use this.
    function automatic logic calc_parity(input logic [31:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/parity_err_tracker.sv
// Parity error bookkeeping: saturating total count, consecutive-error run and RUN/HALT FSM.
module parity_err_tracker
    import parity_codec_pkg::*;
#(
    parameter int unsigned ERR_CNT_W = 8,
    parameter int unsigned ERR_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 acc_good,
    input  logic                 acc_bad,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic                 halted
);

    // ERR_LIMIT is at most 15, so a 4-bit run counter always suffices.
    localparam int unsigned CONSEC_W = 4;

    dec_state_e            state_q, state_d;
    logic [CONSEC_W-1:0]   consec_q, consec_d;
    logic [CONSEC_W-1:0]   consec_inc;
    logic [ERR_CNT_W-1:0]  err_q, err_d;

    assign consec_inc = consec_q + CONSEC_W'(1);

    // Next-state: clr has priority over any accept in the same cycle.
    always_comb begin
        state_d  = state_q;
        consec_d = consec_q;
        err_d    = err_q;
        if (clr) begin
            state_d  = StRun;
            consec_d = '0;
            err_d    = '0;
        end else if (acc_bad) begin
            if (err_q != '1) begin
                err_d = err_q + ERR_CNT_W'(1);
            end
            // Intake stops at the limit, so the run counter never wraps.
            consec_d = consec_inc;
            if (consec_inc >= CONSEC_W'(ERR_LIMIT)) begin
                state_d = StHalt;
            end
        end else if (acc_good) begin
            consec_d = '0;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StRun;
            consec_q <= '0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            consec_q <= consec_d;
            err_q    <= err_d;
        end
    end

    assign err_cnt = err_q;
    assign halted  = (state_q == StHalt);

endmodule

// File: rtl/onehot_parity_decoder.sv
// Receive-side decoder: parity-checks 3-bit index codes and expands them to one-hot words
// behind a registered valid/ready output stage.
// Optional macro PARITY_DECODER_STATS_EN adds word_cnt, a 16-bit count of accepted good words.
module onehot_parity_decoder
    import parity_codec_pkg::*;
#(
    parameter int unsigned CODE_W     = CODE_W_DFLT,
    parameter int unsigned ERR_CNT_W  = 8,
    parameter int unsigned ERR_LIMIT  = 4,
    parameter bit          PARITY_ODD = 1'b0,
    localparam int unsigned OUT_W     = 2 ** CODE_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CODE_W-1:0]    in_code,
    input  logic                 in_par,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_W-1:0]     out_d,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic                 halted
`ifdef PARITY_DECODER_STATS_EN
    ,
    output logic [15:0]          word_cnt
`endif
);

    logic             acc;
    logic             par_ok;
    logic [OUT_W-1:0] dec;
    logic             out_valid_q;
    logic             out_err_q;
    logic [OUT_W-1:0] out_d_q;

    // Output slot is free when empty or being drained this cycle.
    assign in_ready = en & ~halted & (~out_valid_q | out_ready);
    assign acc      = in_valid & in_ready;
    assign par_ok   = (calc_parity(32'({in_code, in_par})) == PARITY_ODD);

    // One-hot expansion; a bad word decodes to all zeros.
    always_comb begin
        dec = '0;
        if (par_ok) begin
            dec[in_code] = 1'b1;
        end
    end

    // Output register: load on accept, otherwise clear valid once consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_d_q     <= '0;
            out_err_q   <= 1'b0;
        end else if (acc) begin
            out_valid_q <= 1'b1;
            out_d_q     <= dec;
            out_err_q   <= ~par_ok;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_d     = out_d_q;
    assign out_err   = out_err_q;

    parity_err_tracker #(
        .ERR_CNT_W (ERR_CNT_W),
        .ERR_LIMIT (ERR_LIMIT)
    ) u_tracker (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .acc_good (acc & par_ok),
        .acc_bad  (acc & ~par_ok),
        .err_cnt  (err_cnt),
        .halted   (halted)
    );

`ifdef PARITY_DECODER_STATS_EN
    logic [15:0] word_cnt_q;

    // Good-word counter, wraps modulo 2^16; clr wins over a same-cycle accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt_q <= '0;
        end else if (clr) begin
            word_cnt_q <= '0;
        end else if (acc && par_ok) begin
            word_cnt_q <= word_cnt_q + 16'd1;
        end
    end

    assign word_cnt = word_cnt_q;
`endif

endmodule

// File: tb/tb_onehot_parity_decoder.sv
// Scoreboard bench for onehot_parity_decoder: default instance plus a narrow-counter instance.
module tb_onehot_parity_decoder;

    typedef struct packed {
        logic       err;
        logic [7:0] d;
    } sb_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       clr;
    logic       in_valid;
    logic [2:0] in_code;
    logic       in_par;
    logic       out_ready;

    logic       in_ready, out_valid, out_err, halted;
    logic [7:0] out_d, err_cnt;
    logic       in_ready_s, out_valid_s, out_err_s, halted_s;
    logic [7:0] out_d_s;
    logic [1:0] err_cnt_s;
`ifdef PARITY_DECODER_STATS_EN
    logic [15:0] word_cnt, word_cnt_s;
`endif

    int  n_vec = 0;
    int  n_err = 0;
    sb_t sb[$];
    bit  exp_ov = 1'b0;

    always #5 clk = ~clk;

    onehot_parity_decoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .in_par    (in_par),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_d     (out_d),
        .out_err   (out_err),
        .err_cnt   (err_cnt),
        .halted    (halted)
`ifdef PARITY_DECODER_STATS_EN
        ,
        .word_cnt  (word_cnt)
`endif
    );

    onehot_parity_decoder #(
        .ERR_CNT_W (2),
        .ERR_LIMIT (15)
    ) dut_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready_s),
        .in_code   (in_code),
        .in_par    (in_par),
        .out_valid (out_valid_s),
        .out_ready (out_ready),
        .out_d     (out_d_s),
        .out_err   (out_err_s),
        .err_cnt   (err_cnt_s),
        .halted    (halted_s)
`ifdef PARITY_DECODER_STATS_EN
        ,
        .word_cnt  (word_cnt_s)
`endif
    );

    // Reference decode: even parity over {code, par}.
    function automatic sb_t exp_word(input logic [2:0] code, input logic par);
        sb_t e;
        e.err = ^{code, par};
        e.d   = e.err ? 8'h00 : (8'h01 << code);
        return e;
    endfunction

    // Advance one clock; retire the presented word if it was consumed at this edge.
    task automatic tick();
        bit pop;
        pop = exp_ov && out_ready;
        @(posedge clk);
        #1;
        if (pop) void'(sb.pop_front());
        exp_ov = (sb.size() != 0);
    endtask

    task automatic send(input logic [2:0] code, input logic par);
        in_valid = 1'b1;
        in_code  = code;
        in_par   = par;
        sb.push_back(exp_word(code, par));
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; in_valid = 1'b0;
        in_code = 3'd0; in_par = 1'b0; out_ready = 1'b0;
        #12;
        n_vec++;
        if (out_valid !== 1'b0 || out_d !== 8'h00 || out_err !== 1'b0 ||
            err_cnt !== 8'h00 || halted !== 1'b0) begin
            n_err++;
            $display("FAIL reset: ov=%b d=%h err=%b cnt=%0d halt=%b, want 0 00 0 0 0",
                     out_valid, out_d, out_err, err_cnt, halted);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_stream();
        logic [2:0] c;
        en = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            c = i[2:0];
            send(c, ^c);
            #1;
            n_vec++;
            if (in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL stream_ready[%0d]: in_ready=%b, want 1", i, in_ready);
            end
            tick();
            if (exp_ov) begin
                n_vec++;
                if (out_valid !== 1'b1 || out_d !== sb[0].d || out_err !== sb[0].err) begin
                    n_err++;
                    $display("FAIL stream_out[%0d]: ov=%b d=%h err=%b, want 1 %h %b",
                             i, out_valid, out_d, out_err, sb[0].d, sb[0].err);
                end
            end
        end
        in_valid = 1'b0;
        tick();
        n_vec++;
        if (out_valid !== 1'b0 || err_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL stream_end: ov=%b cnt=%0d, want 0 0", out_valid, err_cnt);
        end
`ifdef PARITY_DECODER_STATS_EN
        n_vec++;
        if (word_cnt !== 16'd8) begin
            n_err++;
            $display("FAIL stream_word_cnt: got %0d, want 8", word_cnt);
        end
`endif
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send(3'd5, 1'b0);
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_first_ready: in_ready=%b, want 1", in_ready);
        end
        tick();
        // Next word waits while the output is stalled.
        in_code = 3'd2; in_par = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_vec++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_d !== sb[0].d ||
                out_err !== sb[0].err) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: rdy=%b ov=%b d=%h err=%b, want 0 1 %h %b",
                         k, in_ready, out_valid, out_d, out_err, sb[0].d, sb[0].err);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_release_ready: in_ready=%b, want 1", in_ready);
        end
        sb.push_back(exp_word(3'd2, 1'b1));
        tick();
        in_valid = 1'b0;
        n_vec++;
        if (out_valid !== 1'b1 || out_d !== sb[0].d || out_err !== sb[0].err) begin
            n_err++;
            $display("FAIL bp_next: ov=%b d=%h err=%b, want 1 %h %b",
                     out_valid, out_d, out_err, sb[0].d, sb[0].err);
        end
        tick();
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_drain: ov=%b, want 0", out_valid);
        end
    endtask

    task automatic test_single_bad();
        out_ready = 1'b1;
        send(3'd3, 1'b1);
        tick();
        in_valid = 1'b0;
        n_vec++;
        if (out_valid !== 1'b1 || out_d !== 8'h00 || out_err !== 1'b1 ||
            err_cnt !== 8'd1 || halted !== 1'b0) begin
            n_err++;
            $display("FAIL bad_one: ov=%b d=%h err=%b cnt=%0d halt=%b, want 1 00 1 1 0",
                     out_valid, out_d, out_err, err_cnt, halted);
        end
        send(3'd1, 1'b1);
        tick();
        in_valid = 1'b0;
        // Three more bad words: no halt unless the good word failed to reset the run.
        for (int k = 0; k < 3; k++) begin
            send(3'd0, 1'b1);
            tick();
        end
        in_valid = 1'b0;
        tick();
        n_vec++;
        if (halted !== 1'b0 || err_cnt !== 8'd4) begin
            n_err++;
            $display("FAIL bad_run_reset: halt=%b cnt=%0d, want 0 4", halted, err_cnt);
        end
    endtask

    task automatic test_halt();
        logic [2:0] c;
        out_ready = 1'b1;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_vec++;
        if (err_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL halt_pre_clr: cnt=%0d, want 0", err_cnt);
        end
        for (int k = 0; k < 4; k++) begin
            c = k[2:0];
            send(c, ~(^c));
            tick();
            n_vec++;
            if (out_valid !== 1'b1 || out_err !== 1'b1 || out_d !== 8'h00 ||
                halted !== (k == 3)) begin
                n_err++;
                $display("FAIL halt_bad[%0d]: ov=%b err=%b d=%h halt=%b, want 1 1 00 %b",
                         k, out_valid, out_err, out_d, halted, (k == 3));
            end
        end
        // in_valid stays high: nothing may be taken while halted.
        #1;
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL halt_ready: in_ready=%b, want 0", in_ready);
        end
        tick();
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || err_cnt !== 8'd4 || halted !== 1'b1) begin
            n_err++;
            $display("FAIL halt_hold: ov=%b rdy=%b cnt=%0d halt=%b, want 0 0 4 1",
                     out_valid, in_ready, err_cnt, halted);
        end
        in_valid = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_vec++;
        if (halted !== 1'b0 || err_cnt !== 8'd0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL halt_clr: halt=%b cnt=%0d rdy=%b, want 0 0 1",
                     halted, err_cnt, in_ready);
        end
        send(3'd6, 1'b0);
        tick();
        in_valid = 1'b0;
        n_vec++;
        if (out_valid !== 1'b1 || out_d !== sb[0].d || out_err !== sb[0].err) begin
            n_err++;
            $display("FAIL halt_resume: ov=%b d=%h err=%b, want 1 %h %b",
                     out_valid, out_d, out_err, sb[0].d, sb[0].err);
        end
        tick();
    endtask

    task automatic test_clr_accept();
        out_ready = 1'b1;
        send(3'd2, 1'b0);
        tick();
        send(3'd7, 1'b0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        in_valid = 1'b0;
        n_vec++;
        if (err_cnt !== 8'd0 || out_valid !== 1'b1 || out_d !== sb[0].d ||
            out_err !== sb[0].err) begin
            n_err++;
            $display("FAIL clr_accept: cnt=%0d ov=%b d=%h err=%b, want 0 1 %h %b",
                     err_cnt, out_valid, out_d, out_err, sb[0].d, sb[0].err);
        end
        tick();
    endtask

    task automatic test_en_low();
        out_ready = 1'b0;
        send(3'd4, 1'b1);
        tick();
        en = 1'b0;
        in_code = 3'd0; in_par = 1'b0; in_valid = 1'b1;
        #1;
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL en_low_ready: in_ready=%b, want 0", in_ready);
        end
        tick();
        n_vec++;
        if (out_valid !== 1'b1 || out_d !== sb[0].d) begin
            n_err++;
            $display("FAIL en_low_hold: ov=%b d=%h, want 1 %h", out_valid, out_d, sb[0].d);
        end
        out_ready = 1'b1;
        tick();
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL en_low_drain: ov=%b rdy=%b, want 0 0", out_valid, in_ready);
        end
        in_valid = 1'b0;
        en = 1'b1;
    endtask

    task automatic test_saturation();
        out_ready = 1'b1;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int k = 0; k < 5; k++) begin
            send(3'd3, 1'b1);
            tick();
            send(3'd3, 1'b0);
            tick();
        end
        in_valid = 1'b0;
        tick();
        n_vec++;
        if (err_cnt_s !== 2'd3 || halted_s !== 1'b0) begin
            n_err++;
            $display("FAIL sat_narrow: cnt=%0d halt=%b, want 3 0", err_cnt_s, halted_s);
        end
        n_vec++;
        if (err_cnt !== 8'd5 || halted !== 1'b0) begin
            n_err++;
            $display("FAIL sat_wide: cnt=%0d halt=%b, want 5 0", err_cnt, halted);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        send(3'd2, 1'b1);
        tick();
        in_valid = 1'b0;
        n_vec++;
        if (out_valid !== 1'b1 || out_d !== 8'h04) begin
            n_err++;
            $display("FAIL rst_mid_pre: ov=%b d=%h, want 1 04", out_valid, out_d);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || out_d !== 8'h00) begin
            n_err++;
            $display("FAIL rst_mid_async: ov=%b d=%h, want 0 00", out_valid, out_d);
        end
        sb.delete();
        exp_ov = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_single_bad();
        test_halt();
        test_clr_accept();
        test_en_low();
        test_saturation();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/onehot_parity_decoder.md
Name: onehot_parity_decoder

Overview:
- Receive-side companion of the 8-to-3 encoder; sits at the consumer end of the encoded link.
- Accepts 3-bit index codes plus a parity bit over a valid/ready handshake, checks parity and expands each code to an 8-bit one-hot word.
- Registers the result toward a valid/ready sink.
- Counts parity errors and halts intake after a run of consecutive errors until software clears it.

Parameters:
- CODE_W, 3, index width; output width OUT_W = 2**CODE_W (localparam, 8 at default).
- ERR_CNT_W, 8, width of the saturating total-error counter.
- ERR_LIMIT, 4, number of consecutive bad words that forces HALT (legal range 1..15).
- PARITY_ODD, 0, 0 = even parity over {in_code, in_par}, 1 = odd parity.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- en, input, 1, decoder enable; when low, no new words are accepted.
- clr, input, 1, single-cycle pulse; clears the counters and exits HALT.
- in_valid, input, 1, upstream word valid.
- in_ready, output, 1, decoder can accept a word this cycle.
- in_code, input, CODE_W, encoded index.
- in_par, input, 1, parity bit.
- out_valid, output, 1, out_d/out_err hold a word.
- out_ready, input, 1, downstream accepts the word.
- out_d, output, OUT_W, one-hot decoded word.
- out_err, output, 1, parity error on the current output word.
- err_cnt, output, ERR_CNT_W, total parity errors, saturating.
- halted, output, 1, FSM is in HALT.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: out_valid=0, out_d=0, out_err=0, err_cnt=0, halted=0, consecutive-error count=0, FSM=RUN.
- Handshake:
  - Accept = in_valid & in_ready.
  - in_ready = en & (state==RUN) & (!out_valid | out_ready), combinational.
  - One word per cycle is sustained under full flow.
- Latency: 1 cycle. A word accepted at edge N is presented with out_valid=1 after edge N.
- Output hold: out_valid, out_d and out_err stay stable while out_valid & !out_ready.
- Output update: out_valid clears on out_ready only if no new accept occurs in the same cycle.
- Parity check:
  - par_ok = (^{in_code,in_par}) == PARITY_ODD.
  - ok: out_d = 1<<in_code, out_err=0.
  - bad: out_d = 0, out_err=1.
- Counters:
  - Accepted bad word: err_cnt++ (saturates at all-ones, no wrap), consecutive count++.
  - Accepted good word: consecutive count -> 0.
- FSM, RUN -> HALT: an accepted bad word brings the consecutive count to ERR_LIMIT. That word is still output; in_ready drops from the next cycle.
- FSM, HALT -> RUN: on clr. Pending output still drains while halted.
- clr:
  - Zeroes err_cnt and the consecutive count in either state.
  - Coinciding with an accept: the clear wins for the counters, and the word is still decoded and output.
- en low mid-transfer: an already registered output drains normally; no new accepts.
- Reset mid-operation: the pending output is discarded immediately (asynchronous).

Optional Feature:
- Macro PARITY_DECODER_STATS_EN.
- Defined:
  - Adds output word_cnt [15:0], a count of accepted good words.
  - Wraps modulo 2^16.
  - Cleared by clr and by reset.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package parity_codec_pkg holds:
  - CODE_W/OUT_W constants.
  - FSM state typedef {RUN, HALT}.
  - A parity function shared with the encoder side.
- One natural sub-module, parity_err_tracker: consecutive and total error counters plus the FSM. The datapath and handshake stay in the top.

Test Plan:
- Reset, en=1, stream codes 0..7 with correct even parity, out_ready=1 -> out_d = 01,02,04,...,80 one cycle after each accept; err_cnt=0; in_ready held 1.
- Backpressure: send code 5 (par 0) with out_ready=0 for 3 cycles -> out_d=8'h20 held stable, in_ready=0, no loss; the next word is accepted the cycle out_ready rises.
- Single bad word: code 3 with par=1 -> out_d=0, out_err=1, err_cnt=1. A following good word clears the consecutive count; no HALT.
- ERR_LIMIT=4: four consecutive bad words -> 4th is output with out_err=1, halted=1, in_ready=0. A clr pulse gives halted=0, err_cnt=0, and intake resumes.
- Saturation with ERR_CNT_W=2, ERR_LIMIT=15: send 5 bad words, interleaving good words so no HALT -> err_cnt stops at 3.
- rst_n asserted while out_valid=1 with out_ready=0 -> out_valid=0 and out_d=0 immediately, without waiting for a clock edge.
